// File: rtl/whack_pkg.sv
// Shared types, default sizes and the saturating-add helper for the whack-a-mole playfield.
package whack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        UP   = 1'b1
    } mole_state_t;

    localparam int unsigned N_MOLES_DEF = 18;
    localparam int unsigned LIFE_W_DEF  = 4;
    localparam int unsigned CNT_W_DEF   = 8;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_v);
        int unsigned sum;
        sum = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/mole_cell.sv
// One mole: IDLE/UP state plus lifetime countdown. Emits combinational hit/escape events.
// WHACK_PENALTY_EN adds a wrong_o event for whacks on an idle cell.
module mole_cell
    import whack_pkg::*;
#(
    parameter int unsigned LIFE_W = LIFE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              tick_i,
    input  logic              whack_i,
    input  logic              spawn_i,
    input  logic [LIFE_W-1:0] life_ticks_i,
    output logic              up_o,
    output logic              hit_o,
`ifdef WHACK_PENALTY_EN
    output logic              wrong_o,
`endif
    output logic              escape_o
);

    mole_state_t       state_q, state_d;
    logic [LIFE_W-1:0] life_q, life_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            life_q  <= '0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        life_d   = life_q;
        hit_o    = 1'b0;
        escape_o = 1'b0;
`ifdef WHACK_PENALTY_EN
        wrong_o  = 1'b0;
`endif
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef WHACK_PENALTY_EN
                    wrong_o = whack_i;
`endif
                    if (tick_i && spawn_i) begin
                        state_d = UP;
                        life_d  = (life_ticks_i == '0) ? LIFE_W'(1) : life_ticks_i;
                    end
                end
                UP: begin
                    // A hit wins over expiry on the same tick.
                    if (whack_i) begin
                        state_d = IDLE;
                        hit_o   = 1'b1;
                    end else if (tick_i) begin
                        if (life_q == LIFE_W'(1)) begin
                            state_d  = IDLE;
                            escape_o = 1'b1;
                        end else begin
                            life_d = life_q - LIFE_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign up_o = (state_q == UP);

endmodule

// File: rtl/whack_field.sv
// Whack-a-mole playfield: N mole cells, switch-toggle whack detection, saturating scores.
// Define WHACK_PENALTY_EN to count whacks on idle cells as misses.
module whack_field
    import whack_pkg::*;
#(
    parameter int unsigned N_MOLES = N_MOLES_DEF,
    parameter int unsigned LIFE_W  = LIFE_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               tick,
    input  logic [N_MOLES-1:0] switch,
    input  logic [N_MOLES-1:0] spawn,
    input  logic [LIFE_W-1:0]  life_ticks,
    output logic [N_MOLES-1:0] led,
    output logic [N_MOLES-1:0] hit_pulse,
    output logic [N_MOLES-1:0] escape_pulse,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic [N_MOLES-1:0] prev_switch_q;
    logic               primed_q;
    logic [N_MOLES-1:0] whack;
    logic [N_MOLES-1:0] hit_ev, escape_ev, wrong_ev;
    logic [N_MOLES-1:0] hit_pulse_q, escape_pulse_q;
    logic [CNT_W-1:0]   hit_count_q, miss_count_q;
    int unsigned        n_hit, n_miss;

    // Switches already high when reset releases must not read as toggles.
    assign whack = primed_q ? (switch ^ prev_switch_q) : '0;

    for (genvar i = 0; i < N_MOLES; i++) begin : g_cell
        mole_cell #(
            .LIFE_W(LIFE_W)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable_i    (enable),
            .tick_i      (tick),
            .whack_i     (whack[i]),
            .spawn_i     (spawn[i]),
            .life_ticks_i(life_ticks),
            .up_o        (led[i]),
            .hit_o       (hit_ev[i]),
`ifdef WHACK_PENALTY_EN
            .wrong_o     (wrong_ev[i]),
`endif
            .escape_o    (escape_ev[i])
        );
    end

`ifndef WHACK_PENALTY_EN
    assign wrong_ev = '0;
`endif

    always_comb begin
        n_hit  = 0;
        n_miss = 0;
        for (int i = 0; i < N_MOLES; i++) begin
            n_hit  = n_hit + 32'(hit_ev[i]);
            n_miss = n_miss + 32'(escape_ev[i]) + 32'(wrong_ev[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_switch_q  <= '0;
            primed_q       <= 1'b0;
            hit_pulse_q    <= '0;
            escape_pulse_q <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
        end else begin
            prev_switch_q  <= switch;
            primed_q       <= 1'b1;
            hit_pulse_q    <= hit_ev;
            escape_pulse_q <= escape_ev;
            hit_count_q    <= CNT_W'(sat_add(32'(hit_count_q), n_hit, CNT_MAX));
            miss_count_q   <= CNT_W'(sat_add(32'(miss_count_q), n_miss, CNT_MAX));
        end
    end

    assign hit_pulse    = hit_pulse_q;
    assign escape_pulse = escape_pulse_q;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_whack_field.sv
// Randomised and directed bench for whack_field against a behavioural playfield model;
// a second instance with 2-bit counters checks saturation.
module tb_whack_field;

    localparam int N  = 18;
    localparam int LW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          tick = 1'b0;
    logic [N-1:0]  sw = '0;
    logic [N-1:0]  spawn = '0;
    logic [LW-1:0] lt = LW'(1);

    logic [N-1:0]  led, hit_pulse, escape_pulse;
    logic [CW-1:0] hit_count, miss_count;
    logic [N-1:0]  s_led, s_hit_pulse, s_escape_pulse;
    logic [1:0]    s_hit_count, s_miss_count;

    whack_field #(.N_MOLES(N), .LIFE_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .switch(sw), .spawn(spawn),
        .life_ticks(lt), .led(led), .hit_pulse(hit_pulse), .escape_pulse(escape_pulse),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    whack_field #(.N_MOLES(N), .LIFE_W(LW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .switch(sw), .spawn(spawn),
        .life_ticks(lt), .led(s_led), .hit_pulse(s_hit_pulse), .escape_pulse(s_escape_pulse),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: which moles are up, ticks left, running totals since reset.
    bit           m_up[N];
    int           m_life[N];
    logic [N-1:0] m_prev;
    bit           m_primed;
    logic [N-1:0] e_hit, e_esc;
    int           m_hits, m_miss;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [N-1:0] model_led();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_up[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_up[i]   = 1'b0;
            m_life[i] = 0;
        end
        m_prev   = '0;
        m_primed = 1'b0;
        e_hit    = '0;
        e_esc    = '0;
        m_hits   = 0;
        m_miss   = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] toggled;
        toggled = m_primed ? (sw ^ m_prev) : '0;
        e_hit = '0;
        e_esc = '0;
        for (int i = 0; i < N; i++) begin
            if (!enable) begin
                m_up[i] = 1'b0;
            end else if (m_up[i]) begin
                if (toggled[i]) begin
                    e_hit[i] = 1'b1;
                    m_up[i]  = 1'b0;
                    m_hits++;
                end else if (tick) begin
                    m_life[i]--;
                    if (m_life[i] == 0) begin
                        e_esc[i] = 1'b1;
                        m_up[i]  = 1'b0;
                        m_miss++;
                    end
                end
            end else begin
`ifdef WHACK_PENALTY_EN
                if (toggled[i]) m_miss++;
`endif
                if (tick && spawn[i]) begin
                    m_up[i]   = 1'b1;
                    m_life[i] = (int'(lt) == 0) ? 1 : int'(lt);
                end
            end
        end
        m_prev   = sw;
        m_primed = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".led"}, 32'(led), 32'(model_led()));
        check_eq({tag, ".hit_pulse"}, 32'(hit_pulse), 32'(e_hit));
        check_eq({tag, ".escape_pulse"}, 32'(escape_pulse), 32'(e_esc));
        check_eq({tag, ".hit_count"}, 32'(hit_count), 32'(clamp(m_hits, 255)));
        check_eq({tag, ".miss_count"}, 32'(miss_count), 32'(clamp(m_miss, 255)));
        check_eq({tag, ".sat_hit"}, 32'(s_hit_count), 32'(clamp(m_hits, 3)));
        check_eq({tag, ".sat_miss"}, 32'(s_miss_count), 32'(clamp(m_miss, 3)));
    endtask

    task automatic cycle(input string tag, input bit en, input bit t, input logic [N-1:0] s,
                         input logic [N-1:0] p, input logic [LW-1:0] l);
        @(negedge clk);
        enable = en;
        tick   = t;
        sw     = s;
        spawn  = p;
        lt     = l;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int miss_before;
        logic [N-1:0] r_sw;
        model_reset();
        sw = N'(1);
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Switch 0 high through reset must not register as a whack.
        for (int k = 0; k < 3; k++) cycle("primed", 1, 0, sw, '0, LW'(3));
        check_eq("primed.hit_count", 32'(hit_count), 32'd0);

        // Lifetime 3, no whack: escapes on the third tick.
        cycle("spawn5", 1, 1, sw, N'(1 << 5), LW'(3));
        for (int k = 0; k < 3; k++) begin
            cycle("life5.idle", 1, 0, sw, '0, LW'(3));
            cycle("life5.tick", 1, 1, sw, '0, LW'(3));
        end
        check_eq("escape.miss_count", 32'(miss_count), 32'd1);

        // Two simultaneous hits, one mole left standing.
        cycle("spawn012", 1, 1, sw, N'(7), LW'(3));
        cycle("whack01", 1, 0, sw ^ N'(3), '0, LW'(3));
        check_eq("whack01.hit_pulse", 32'(hit_pulse[2:0]), 32'b011);
        check_eq("whack01.led2", 32'(led[2]), 32'd1);

        // Whack lands on the same tick mole 2 would expire.
        cycle("m2.tick1", 1, 1, sw, '0, LW'(3));
        cycle("m2.tick2", 1, 1, sw, '0, LW'(3));
        miss_before = m_miss;
        cycle("m2.whack_expire", 1, 1, sw ^ N'(1 << 2), '0, LW'(3));
        check_eq("hit_vs_expire.pulse", 32'(hit_pulse[2]), 32'd1);
        check_eq("hit_vs_expire.miss", 32'(miss_count), 32'(miss_before));

        // Five hits push the 2-bit counter to its ceiling.
        for (int k = 0; k < 5; k++) begin
            cycle("sat.spawn", 1, 1, sw, N'(1 << 9), LW'(0));
            cycle("sat.whack", 1, 0, sw ^ N'(1 << 9), '0, LW'(0));
        end
        check_eq("sat.hit_count", 32'(s_hit_count), 32'd3);

        // Whack on an empty cell.
        miss_before = int'(miss_count);
        cycle("wrong7", 1, 0, sw ^ N'(1 << 7), '0, LW'(2));
`ifdef WHACK_PENALTY_EN
        check_eq("wrong7.miss_delta", 32'(int'(miss_count) - miss_before), 32'd1);
`else
        check_eq("wrong7.miss_delta", 32'(int'(miss_count) - miss_before), 32'd0);
`endif

        // Disable with moles up: all clear, no pulses, counters hold.
        cycle("dis.spawn", 1, 1, sw, N'(18'h3F000), LW'(5));
        cycle("dis.off", 0, 1, sw ^ N'(18'h01000), N'(18'h00F00), LW'(5));
        cycle("dis.on", 1, 0, sw, '0, LW'(5));

        for (int k = 0; k < 3000; k++) begin
            r_sw = sw ^ N'($urandom & $urandom & $urandom);
            cycle("rand", $urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, r_sw,
                  N'($urandom & $urandom), LW'($urandom_range(0, 15)));
            if (k == 1500) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
